// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state encoding and rstatus codes for the multdiv sequencer
package cpu_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_t;

    localparam logic [31:0] RSTATUS_MULT = 32'd4;
    localparam logic [31:0] RSTATUS_DIV  = 32'd5;
endpackage

// File: rtl/md_watchdog.sv
// rtl/md_watchdog.sv - clear/enable cycle counter with terminal-count flag
module md_watchdog #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_WIDTH      = 6
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);
    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - issue/complete controller between execute stage and iterative multdiv unit
module multdiv_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TAG_WIDTH      = 5,
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_WIDTH      = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_op_valid,
    input  logic                  i_op_is_mult,
    input  logic                  i_op_is_div,
    input  logic [DATA_WIDTH-1:0] i_op_a,
    input  logic [DATA_WIDTH-1:0] i_op_b,
    input  logic [TAG_WIDTH-1:0]  i_op_tag,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] o_md_a,
    output logic [DATA_WIDTH-1:0] o_md_b,
    output logic                  o_md_ctrl_mult,
    output logic                  o_md_ctrl_div,
    input  logic [DATA_WIDTH-1:0] i_md_result,
    input  logic                  i_md_exception,
    input  logic                  i_md_result_rdy,
    output logic                  o_stall,
    output logic                  o_res_valid,
    output logic [DATA_WIDTH-1:0] o_res_data,
    output logic [TAG_WIDTH-1:0]  o_res_tag,
    output logic                  o_res_exception,
    output logic [31:0]           o_res_status
);
    md_state_t             r_state;
    md_state_t             w_next;
    logic                  r_is_mult;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [DATA_WIDTH-1:0] r_md_a;
    logic [DATA_WIDTH-1:0] r_md_b;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic [TAG_WIDTH-1:0]  r_res_tag;
    logic                  r_res_exc;
    logic [31:0]           r_res_status;

    logic w_op_req;
    logic w_accept;
    logic w_complete;
    logic w_timeout;
    logic w_stall;
    logic w_ctrl_mult;
    logic w_ctrl_div;
    logic w_wd_terminal;
    logic w_cpl_exc;

    assign w_op_req = i_op_valid & (i_op_is_mult | i_op_is_div);

    md_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (r_state != ST_BUSY),
        .i_enable  (r_state == ST_BUSY),
        .o_terminal(w_wd_terminal)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Flush beats a same-cycle rdy; the restarted unit makes any later stale rdy harmless.
    always_comb begin
        w_next      = r_state;
        w_stall     = 1'b0;
        w_ctrl_mult = 1'b0;
        w_ctrl_div  = 1'b0;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = w_op_req & ~i_flush;
                if (w_stall) begin
                    w_accept = 1'b1;
                    w_next   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_ctrl_mult = r_is_mult;
                w_ctrl_div  = ~r_is_mult;
                w_stall     = ~i_flush;
                w_next      = i_flush ? ST_IDLE : ST_BUSY;
            end
            ST_BUSY: begin
                w_stall = ~i_flush;
                if (i_flush) begin
                    w_next = ST_IDLE;
                end else if (i_md_result_rdy) begin
                    w_complete = 1'b1;
                    w_next     = ST_DONE;
                end else if (w_wd_terminal) begin
                    w_complete = 1'b1;
                    w_timeout  = 1'b1;
                    w_next     = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_cpl_exc = w_timeout | i_md_exception;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_is_mult    <= 1'b0;
            r_tag        <= '0;
            r_md_a       <= '0;
            r_md_b       <= '0;
            r_res_data   <= '0;
            r_res_tag    <= '0;
            r_res_exc    <= 1'b0;
            r_res_status <= '0;
        end else begin
            if (w_accept) begin
                r_is_mult <= i_op_is_mult;
                r_tag     <= i_op_tag;
                r_md_a    <= i_op_a;
                r_md_b    <= i_op_b;
            end
            if (w_complete) begin
                r_res_tag    <= r_tag;
                r_res_exc    <= w_cpl_exc;
                r_res_data   <= w_cpl_exc ? '0 : i_md_result;
                r_res_status <= w_cpl_exc ? (r_is_mult ? RSTATUS_MULT : RSTATUS_DIV) : 32'd0;
            end
        end
    end

    assign o_md_a          = r_md_a;
    assign o_md_b          = r_md_b;
    assign o_md_ctrl_mult  = w_ctrl_mult;
    assign o_md_ctrl_div   = w_ctrl_div;
    assign o_stall         = w_stall;
    assign o_res_valid     = (r_state == ST_DONE);
    assign o_res_data      = r_res_data;
    assign o_res_tag       = r_res_tag;
    assign o_res_exception = r_res_exc;
    assign o_res_status    = r_res_status;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - self-checking bench for multdiv_sequencer
module tb_multdiv_sequencer;
    localparam int DW = 32;
    localparam int TW = 5;
    localparam int TO = 40;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          op_valid, op_is_mult, op_is_div, flush;
    logic [DW-1:0] op_a, op_b, md_result;
    logic [TW-1:0] op_tag;
    logic          md_exception, md_result_rdy;
    logic [DW-1:0] md_a, md_b, res_data;
    logic          md_ctrl_mult, md_ctrl_div, stall, res_valid, res_exception;
    logic [TW-1:0] res_tag;
    logic [31:0]   res_status;

    always #5 clk = ~clk;

    multdiv_sequencer #(
        .DATA_WIDTH(DW), .TAG_WIDTH(TW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(6)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_op_valid(op_valid), .i_op_is_mult(op_is_mult), .i_op_is_div(op_is_div),
        .i_op_a(op_a), .i_op_b(op_b), .i_op_tag(op_tag), .i_flush(flush),
        .o_md_a(md_a), .o_md_b(md_b),
        .o_md_ctrl_mult(md_ctrl_mult), .o_md_ctrl_div(md_ctrl_div),
        .i_md_result(md_result), .i_md_exception(md_exception), .i_md_result_rdy(md_result_rdy),
        .o_stall(stall), .o_res_valid(res_valid), .o_res_data(res_data),
        .o_res_tag(res_tag), .o_res_exception(res_exception), .o_res_status(res_status)
    );

    int n_checks = 0;
    int n_pass = 0;
    int tot_pulses = 0, tot_strobes = 0, exp_pulses = 0, exp_strobes = 0;
    bit have_last = 0;
    logic [DW-1:0] last_data;
    logic [TW-1:0] last_tag;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (md_ctrl_mult || md_ctrl_div) tot_pulses++;
            if (res_valid) tot_strobes++;
        end
    end

    task automatic check_cleared(input string pfx);
        check_eq({pfx, ".ctrl"}, {md_ctrl_mult, md_ctrl_div}, 0);
        check_eq({pfx, ".stall"}, stall, 0);
        check_eq({pfx, ".res_valid"}, res_valid, 0);
        check_eq({pfx, ".res_exc"}, res_exception, 0);
        check_eq({pfx, ".md_ab"}, {md_a, md_b}, 0);
        check_eq({pfx, ".res_data"}, res_data, 0);
        check_eq({pfx, ".res_tag"}, res_tag, 0);
        check_eq({pfx, ".res_status"}, res_status, 0);
    endtask

    // rdy_after: BUSY cycle (1-based) in which the unit model raises rdy; > TO means never.
    // flush_at: BUSY cycle (1-based) carrying the flush; 0 means no flush.
    task automatic run_op(input string name, input bit is_mult, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [TW-1:0] tag,
                          input int rdy_after, input int flush_at);
        int n_busy, limit, exp_stalls, pulse_c, strobe_c, strobes, stalls, pm, pd;
        bit timeout, unit_exc, exp_exc, flushed, released;
        logic [DW-1:0] unit_res, exp_data;
        logic [31:0] exp_status;

        timeout  = (rdy_after > TO);
        n_busy   = timeout ? TO : rdy_after;
        flushed  = (flush_at != 0);
        unit_exc = !is_mult && (b == 0);
        if (is_mult) unit_res = a * b;
        else if (b == 0) unit_res = '0;
        else unit_res = a / b;
        exp_exc    = timeout || unit_exc;
        exp_data   = exp_exc ? '0 : unit_res;
        exp_status = exp_exc ? (is_mult ? 32'd4 : 32'd5) : 32'd0;
        exp_stalls = flushed ? flush_at + 1 : n_busy + 2;
        limit      = flushed ? rdy_after + 6 : n_busy + 4;

        pulse_c = -1; strobe_c = -1; strobes = 0; stalls = 0; pm = 0; pd = 0; released = 0;
        for (int c = 0; c < limit; c++) begin
            @(posedge clk); #1;
            op_valid      = !released;
            op_is_mult    = is_mult;
            op_is_div     = !is_mult;
            op_a          = a;
            op_b          = b;
            op_tag        = tag;
            flush         = flushed && (c == flush_at + 1);
            md_result_rdy = (pulse_c >= 0) && (c == pulse_c + rdy_after);
            md_result     = unit_res;
            md_exception  = unit_exc;
            @(negedge clk);
            if (c == 0 && have_last) begin
                check_eq({name, ".hold_data"}, res_data, last_data);
                check_eq({name, ".hold_tag"}, res_tag, last_tag);
            end
            if (md_ctrl_mult || md_ctrl_div) begin
                pulse_c = c;
                if (md_ctrl_mult) pm++;
                if (md_ctrl_div) pd++;
                check_eq({name, ".md_ab"}, {md_a, md_b}, {a, b});
            end
            if (stall) stalls++;
            if (flushed && c == flush_at + 2) check_eq({name, ".stall_after_flush"}, stall, 0);
            if (flush) released = 1;
            if (res_valid) begin
                strobes++;
                strobe_c = c;
                check_eq({name, ".data"}, res_data, exp_data);
                check_eq({name, ".tag"}, res_tag, tag);
                check_eq({name, ".exc"}, res_exception, exp_exc);
                check_eq({name, ".status"}, res_status, exp_status);
                break;
            end
        end
        flush = 0;
        md_result_rdy = 0;

        check_eq({name, ".pulses"}, {pm[7:0], pd[7:0]}, {is_mult ? 8'd1 : 8'd0, is_mult ? 8'd0 : 8'd1});
        check_eq({name, ".strobes"}, strobes, flushed ? 0 : 1);
        check_eq({name, ".stall_cycles"}, stalls, exp_stalls);
        if (!flushed) begin
            check_eq({name, ".latency"}, strobe_c, n_busy + 2);
            have_last = 1;
            last_data = exp_data;
            last_tag  = tag;
        end
        exp_pulses++;
        if (!flushed) exp_strobes++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            op_valid = 0;
            flush = 0;
            md_result_rdy = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 0;
        op_valid = 0; op_is_mult = 0; op_is_div = 0; flush = 0;
        op_a = 0; op_b = 0; op_tag = 0;
        md_result = 0; md_exception = 0; md_result_rdy = 0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        @(posedge clk); #1;
        rst_n = 1;
        idle_cycles(2);

        run_op("mult3x7", 1, 32'd3, 32'd7, 5'd10, 32, 0);
        run_op("div8by0", 0, 32'd8, 32'd0, 5'd3, 5, 0);
        run_op("flush_busy5", 1, 32'd11, 32'd13, 5'd4, 12, 5);
        run_op("after_flush", 0, 32'd100, 32'd7, 5'd9, 3, 0);
        run_op("timeout_mult", 1, 32'd5, 32'd6, 5'd7, 99, 0);
        run_op("flush_with_rdy", 0, 32'd50, 32'd5, 5'd2, 6, 6);
        run_op("b2b_mult", 1, 32'hFFFF_FFFF, 32'd2, 5'd1, 4, 0);
        run_op("b2b_div", 0, 32'd1000, 32'd10, 5'd31, 7, 0);

        // reset asserted mid-BUSY: everything must clear without waiting for an edge
        @(posedge clk); #1;
        op_valid = 1; op_is_mult = 1; op_is_div = 0; op_a = 32'd9; op_b = 32'd9; op_tag = 5'd6;
        repeat (8) @(posedge clk);
        #3;
        op_valid = 0;
        rst_n = 0;
        #1;
        check_cleared("reset_busy");
        exp_pulses++;
        have_last = 0;
        @(posedge clk); #1;
        rst_n = 1;
        idle_cycles(2);

        for (int i = 0; i < 10; i++) begin
            bit m;
            logic [DW-1:0] a, b;
            int ra, fa;
            m  = $urandom_range(0, 1);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            ra = $urandom_range(1, 44);
            fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (ra > TO) ? TO : ra) : 0;
            run_op($sformatf("rand%0d", i), m, a, b, 5'($urandom), ra, fa);
        end

        idle_cycles(3);
        check_eq("total_pulses", tot_pulses, exp_pulses);
        check_eq("total_strobes", tot_strobes, exp_strobes);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
